// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared encodings and defaults for the ALU operand stage
package alu_operand_stage_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RA_W_DEFAULT = 5;

    // Operand A source select
    localparam logic [1:0] SRC1_RS1  = 2'b10;
    localparam logic [1:0] SRC1_PC   = 2'b11;
    localparam logic [1:0] SRC1_ZERO = 2'b00;

    // Operand B source select
    localparam logic [1:0] SRC2_RS2  = 2'b10;
    localparam logic [1:0] SRC2_IMM  = 2'b11;
    localparam logic [1:0] SRC2_INC  = 2'b01;
    localparam logic [1:0] SRC2_ZERO = 2'b00;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-source forwarding priority mux with load-match detect
module fwd_select #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic [XLEN-1:0] regdata_i,
    input  logic            mem_wen_i,
    input  logic            mem_is_load_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_wen_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] value_o,
    output logic            load_match_o
);

    logic fwd_on;
    logic rs_zero;
    logic mem_hit;
    logic wb_hit;

    assign fwd_on  = (FWD_EN != 0);
    assign rs_zero = (rs_i == '0);

    // A load in MEM has no data yet, so it never forwards; it only raises load_match.
    assign mem_hit = fwd_on && mem_wen_i && !mem_is_load_i && (mem_rd_i == rs_i);
    assign wb_hit  = fwd_on && wb_wen_i && (wb_rd_i == rs_i);

    // Priority: x0 reads zero, then the younger MEM result, then WB, then the register file.
    always_comb begin
        value_o = regdata_i;
        if (rs_zero) begin
            value_o = '0;
        end else if (mem_hit) begin
            value_o = mem_data_i;
        end else if (wb_hit) begin
            value_o = wb_data_i;
        end
    end

    assign load_match_o = fwd_on && mem_wen_i && mem_is_load_i
                          && (mem_rd_i != '0) && (mem_rd_i == rs_i);

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered ALU operand select with forwarding and load-use stall
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int RA_W      = RA_W_DEFAULT,
    parameter int INC_CONST = 4,
    parameter int FWD_EN    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    input  logic [XLEN-1:0] regdata1,
    input  logic [XLEN-1:0] regdata2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [1:0]      alusrc1,
    input  logic [1:0]      alusrc2,
    input  logic            mem_wen,
    input  logic            mem_is_load,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_wen,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aludatain1,
    output logic [XLEN-1:0] aludatain2,
    output logic [XLEN-1:0] storedata
);

    localparam logic [XLEN-1:0] INC_VAL = XLEN'(INC_CONST);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_load_match;
    logic            rs2_load_match;
    logic            hazard;
    logic            capture;

    logic [XLEN-1:0] opa_sel;
    logic [XLEN-1:0] opb_sel;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] store_q, store_d;

    fwd_select #(
        .XLEN   (XLEN),
        .RA_W   (RA_W),
        .FWD_EN (FWD_EN)
    ) u_fwd_rs1 (
        .rs_i          (rs1),
        .regdata_i     (regdata1),
        .mem_wen_i     (mem_wen),
        .mem_is_load_i (mem_is_load),
        .mem_rd_i      (mem_rd),
        .mem_data_i    (mem_data),
        .wb_wen_i      (wb_wen),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .value_o       (rs1_val),
        .load_match_o  (rs1_load_match)
    );

    fwd_select #(
        .XLEN   (XLEN),
        .RA_W   (RA_W),
        .FWD_EN (FWD_EN)
    ) u_fwd_rs2 (
        .rs_i          (rs2),
        .regdata_i     (regdata2),
        .mem_wen_i     (mem_wen),
        .mem_is_load_i (mem_is_load),
        .mem_rd_i      (mem_rd),
        .mem_data_i    (mem_data),
        .wb_wen_i      (wb_wen),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .value_o       (rs2_val),
        .load_match_o  (rs2_load_match)
    );

    // rs1 only matters when operand A actually reads it; rs2 always feeds storedata.
    assign hazard = (rs1_load_match && (alusrc1 == SRC1_RS1)) || rs2_load_match;

    // Ready never looks at in_valid, so decode can rely on it without a combinational loop.
    assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
    assign capture  = in_valid && in_ready;

    // Operand A source mux; both 0x encodings select zero.
    always_comb begin
        opa_sel = '0;
        case (alusrc1)
            SRC1_RS1:  opa_sel = rs1_val;
            SRC1_PC:   opa_sel = pc;
            SRC1_ZERO: opa_sel = '0;
            default:   opa_sel = '0;
        endcase
    end

    // Operand B source mux.
    always_comb begin
        opb_sel = '0;
        case (alusrc2)
            SRC2_RS2:  opb_sel = rs2_val;
            SRC2_IMM:  opb_sel = imm;
            SRC2_INC:  opb_sel = INC_VAL;
            SRC2_ZERO: opb_sel = '0;
            default:   opb_sel = '0;
        endcase
    end

    // Slot next state: flush kills, capture loads, consume empties, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        store_d = store_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            opa_d   = opa_sel;
            opb_d   = opb_sel;
            store_d = rs2_val;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset wins over flush and capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            store_q <= '0;
        end else begin
            valid_q <= valid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            store_q <= store_d;
        end
    end

    assign out_valid  = valid_q;
    assign aludatain1 = opa_q;
    assign aludatain2 = opb_q;
    assign storedata  = store_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered successor to the combinational ALU source muxes; sits between decode and execute in the pipelined core.
- Selects ALU operand A (rs1 / pc / zero) and operand B (rs2 / imm / increment constant) and resolves rs1/rs2 through a two-level forwarding network (MEM, WB).
- Detects load-use hazards and registers the result into a single-entry valid/ready pipeline slot with flush.

Parameters:
- XLEN, 32, datapath width of register data, pc, imm and operands.
- RA_W, 5, register address width; address 0 is hard-wired zero and is never forwarded.
- INC_CONST, 4, value driven on operand B when alusrc2 = 2'b01; zero-extended to XLEN.
- FWD_EN, 1, 1 = forwarding and load-use stall enabled; 0 = raw regdata used, no hazard stall.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the slot content and the current capture.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- rs1, rs2  in  RA_W each  source register addresses.
- regdata1, regdata2  in  XLEN each  register file read data, current cycle.
- pc, imm  in  XLEN each  instruction pc and sign-extended immediate.
- alusrc1  in  2  10 = rs1, 11 = pc, 0x = zero.
- alusrc2  in  2  10 = rs2, 11 = imm, 01 = INC_CONST, 00 = zero.
- mem_wen, mem_is_load  in  1 each  MEM-stage instruction writes rd / is a load.
- mem_rd  in  RA_W  MEM-stage destination.
- mem_data  in  XLEN  MEM-stage ALU result.
- wb_wen  in  1  WB-stage writes rd.
- wb_rd  in  RA_W  WB-stage destination.
- wb_data  in  XLEN  WB-stage result.
- out_valid  out  1  slot holds a valid instruction.
- out_ready  in  1  execute consumes the slot.
- aludatain1, aludatain2  out  XLEN each  registered ALU operands.
- storedata  out  XLEN  registered forwarded rs2 value, independent of alusrc2.

Behaviour:
- Reset: out_valid, aludatain1, aludatain2 and storedata are 0 on the clock after rst is high. rst has priority over flush and capture.
- Forwarding per source s in {rs1, rs2}:
  - s == 0: value = 0.
  - Else if mem_wen && !mem_is_load && mem_rd == s: value = mem_data (MEM wins over WB).
  - Else if wb_wen && wb_rd == s: value = wb_data.
  - Else: value = regdata.
- Load-use hazard: FWD_EN && mem_wen && mem_is_load && mem_rd != 0 && mem_rd matches a source actually used.
  - rs1 is used when alusrc1 == 10.
  - rs2 is always used, because storedata needs it.
- in_ready = (!out_valid || out_ready) && !hazard && !flush. Combinational; in_ready must not depend on in_valid.
- Capture on in_valid && in_ready. On the next edge the selected operands and storedata are registered and out_valid = 1. Latency is exactly 1 cycle.
- Consume without a new capture (out_valid && out_ready, no capture): out_valid = 0 and the data registers hold their old values.
- Backpressure (out_valid && !out_ready): all outputs are held bit-stable.
- Hazard while the slot drains: no capture, so a bubble is inserted and out_valid = 0 after the consume. Upstream must re-present regdata every cycle while stalled.
- flush: out_valid = 0 on the next edge. Any capture that cycle is dropped. Data registers are don't-care.
- Simultaneous consume and capture: the slot is overwritten and out_valid stays 1 (full throughput, one instruction per cycle).
- FWD_EN = 0: raw regdata is used, the rs == 0 rule is still applied, and hazard is tied to 0.

Decomposition:
- Shared package holds:
  - localparams for the alusrc encodings: SRC1_RS1 = 2'b10, SRC1_PC = 2'b11, SRC1_ZERO = 2'b00, SRC2_RS2 = 2'b10, SRC2_IMM = 2'b11, SRC2_INC = 2'b01, SRC2_ZERO = 2'b00.
  - The XLEN default.
- One natural sub-module, fwd_select: instantiated twice (rs1, rs2); purely combinational priority mux plus per-source load-match output.

Test Plan:
1. Reset then idle: hold rst 2 cycles -> out_valid = 0, all data outputs 0, in_ready = 1.
2. Operand select:
   - rs1 = 3, regdata1 = 0x10, alusrc1 = 10, alusrc2 = 01 -> next cycle aludatain1 = 0x10, aludatain2 = 0x4.
   - alusrc1 = 11, pc = 0x400 -> aludatain1 = 0x400.
3. Forward priority: rs1 = 5; mem_wen, mem_rd = 5, mem_data = 0xAA; wb_wen, wb_rd = 5, wb_data = 0xBB -> aludatain1 = 0xAA.
   - Drop mem_wen -> 0xBB.
   - rs1 = 0 with both matching -> 0.
4. Load-use stall: mem_is_load, mem_rd = 7, rs2 = 7, alusrc2 = 11 -> in_ready = 0 for that cycle and out_valid drops to 0 after the consume.
   - Next cycle the load moves to WB with wb_data = 0x55 -> capture, storedata = 0x55.
5. Backpressure: out_valid = 1, out_ready = 0 for 3 cycles while the inputs change -> outputs are bit-stable and in_ready = 0.
6. Flush: flush with in_valid = 1 and out_valid = 1 -> out_valid = 0 next cycle, nothing captured.
   - Back-to-back streaming (out_ready = 1) -> one capture per cycle.
